// File: rtl/chunk_subtractor_seq.sv
// Multi-cycle N-bit subtractor d = a - b - bin, C bits per clock, borrow kept in a register.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module chunk_subtractor_seq #(
    parameter int unsigned N = 12,
    parameter int unsigned C = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
`ifdef SUB_OVF_EN
    output logic         ovf,
`endif
    output logic         borrow
);

    localparam int unsigned NCH = N / C;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(NCH - 1);
    localparam logic [N-1:0]  CH_MASK = N'({C{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          brw_q, brw_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  d_q, d_d;
    logic          borrow_q, borrow_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef SUB_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    int unsigned   sh;
    logic [N-1:0]  a_shift, b_shift;
    logic [C-1:0]  a_chunk, b_chunk;
    logic [C:0]    chunk_res;

    // Next-state, chunk datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        brw_d    = brw_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        sh        = C * 32'(k_q);
        a_shift   = a_q >> sh;
        b_shift   = b_q >> sh;
        a_chunk   = a_shift[C-1:0];
        b_chunk   = b_shift[C-1:0];
        // Bit C of the (C+1)-bit difference is the chunk borrow-out
        chunk_res = {1'b0, a_chunk} - {1'b0, b_chunk} - (C+1)'(brw_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    k_d     = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                d_d    = (d_q & ~(CH_MASK << sh)) | (N'(chunk_res[C-1:0]) << sh);
                brw_d  = chunk_res[C];
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = chunk_res[C];
`ifdef SUB_OVF_EN
                    ovf_d    = (a_q[N-1] ^ b_q[N-1]) & (d_d[N-1] ^ a_q[N-1]);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            brw_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            brw_q    <= brw_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign d      = d_q;
    assign borrow = borrow_q;
`ifdef SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_chunk_subtractor_seq.sv
// Self-checking bench for chunk_subtractor_seq (N=12/C=3 and N=8/C=8 instances).
// Define SUB_OVF_EN to also check the overflow output.
module tb_chunk_subtractor_seq;

    localparam int unsigned N   = 12;
    localparam int unsigned C   = 3;
    localparam int unsigned NCH = N / C;
    localparam int unsigned NV  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         bin;
    logic         busy, done, borrow;
    logic [N-1:0] d;
    logic         ovf_w;

    logic         start8;
    logic [7:0]   a8, b8;
    logic         bin8;
    logic         busy8, done8, borrow8;
    logic [7:0]   d8;
    logic         ovf8_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunk_subtractor_seq #(.N(N), .C(C)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d),
`ifdef SUB_OVF_EN
        .ovf(ovf_w),
`endif
        .borrow(borrow)
    );

    chunk_subtractor_seq #(.N(8), .C(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8),
`ifdef SUB_OVF_EN
        .ovf(ovf8_w),
`endif
        .borrow(borrow8)
    );

`ifndef SUB_OVF_EN
    assign ovf_w  = 1'b0;
    assign ovf8_w = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] exp_d;
        logic         exp_brw;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: whole-word integer arithmetic, independent of chunking
    function automatic logic [N+1:0] ref_model(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                               input logic rbin);
        int s, ss;
        logic [N-1:0] rd;
        logic rbrw, rovf;
        s    = int'(ra) - int'(rb) - int'(rbin);
        rd   = N'(s);
        rbrw = (s < 0);
        ss   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
        rovf = (ss > 2047) || (ss < -2048);
        return {rovf, rbrw, rd};
    endfunction

    // Caller at a negedge: drive one start cycle, leave at negedge of RUN cycle 1
    task automatic start_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ibin);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks busy in RUN cycles then the done cycle; poke>0 re-pulses start with other operands
    task automatic expect_run(input string name, input logic [N-1:0] ed, input logic eb,
                              input logic eo, input int poke);
        for (int i = 1; i <= int'(NCH); i++) begin
            chk({name, "_busy"}, 32'(busy), 32'd1);
            chk({name, "_nodone"}, 32'(done), 32'd0);
            if (i == poke) begin
                a = 12'h0FF; b = 12'h000; bin = 1'b0; start = 1'b1;
            end else begin
                a = N'($urandom); b = N'($urandom); bin = 1'($urandom); start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
        chk({name, "_d"}, 32'(d), 32'(ed));
        chk({name, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SUB_OVF_EN
        chk({name, "_ovf"}, 32'(ovf_w), 32'(eo));
`else
        if (eo !== eo) n_err++;
`endif
    endtask

    initial begin
        logic [N+1:0] r;

        vecs[0] = '{12'h345, 12'h123, 1'b0, 12'h222, 1'b0, 1'b0};
        vecs[1] = '{12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0};
        vecs[2] = '{12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1};
        vecs[3] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0};
        vecs[4] = '{12'h800, 12'h000, 1'b1, 12'h7FF, 1'b0, 1'b1};
        for (int i = 5; i < int'(NV); i++) begin
            vecs[i].a   = N'($urandom);
            vecs[i].b   = N'($urandom);
            vecs[i].bin = 1'($urandom);
            r = ref_model(vecs[i].a, vecs[i].b, vecs[i].bin);
            vecs[i].exp_d   = r[N-1:0];
            vecs[i].exp_brw = r[N];
            vecs[i].exp_ovf = r[N+1];
        end

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf_w), 32'd0);

        // Table-driven single operations with a hold check in the following IDLE cycle
        for (int i = 0; i < int'(NV); i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            expect_run($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_brw, vecs[i].exp_ovf, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_idle_done", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_hold_d", i), 32'(d), 32'(vecs[i].exp_d));
        end

        // Back-to-back: start driven in the done cycle
        start_op(12'h005, 12'h005, 1'b1);
        expect_run("b2b_first", 12'hFFF, 1'b1, 1'b0, 0);
        start_op(12'h010, 12'h001, 1'b0);
        expect_run("b2b_second", 12'h00F, 1'b0, 1'b0, 0);
        @(negedge clk);

        // start re-pulsed during RUN is ignored
        start_op(12'h345, 12'h123, 1'b0);
        expect_run("ignore_start", 12'h222, 1'b0, 1'b0, 2);
        @(negedge clk);
        chk("ignore_start_idle", 32'(busy), 32'd0);

        // Reset in RUN cycle 2 clears outputs asynchronously
        start_op(12'h345, 12'h123, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(12'h000, 12'h001, 1'b0);
        expect_run("after_abort", 12'hFFF, 1'b1, 1'b0, 0);
        @(negedge clk);

        // Degenerate C = N: one RUN cycle, done in cycle 2
        a8 = 8'h45; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        chk("n8_busy", 32'(busy8), 32'd1);
        chk("n8_nodone", 32'(done8), 32'd0);
        @(negedge clk);
        chk("n8_done", 32'(done8), 32'd1);
        chk("n8_d", 32'(d8), 32'h22);
        chk("n8_borrow", 32'(borrow8), 32'd0);
        a8 = 8'h7F; b8 = 8'hFF; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("n8_ovf_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        chk("n8_ovf_done", 32'(done8), 32'd1);
        chk("n8_ovf_d", 32'(d8), 32'h80);
        chk("n8_ovf_borrow", 32'(borrow8), 32'd1);
`ifdef SUB_OVF_EN
        chk("n8_ovf", 32'(ovf8_w), 32'd1);
`endif
        @(negedge clk);
        chk("n8_idle_done", 32'(done8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
